// File: rtl/register_file_multi_port_if.sv
// Bundles the read and write port signals of the multi-port register file.
// The master drives requests and the slave returns ReadData.
interface register_file_multi_port_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_READ     = 2,
    parameter int unsigned N_WRITE    = 2
);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [N_READ-1:0]                  ReadEnable;
    logic [N_READ-1:0][ADDR_WIDTH-1:0]  ReadAddr;
    logic [N_READ-1:0][DATA_WIDTH-1:0]  ReadData;
    logic [N_WRITE-1:0]                 WriteEnable;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0] WriteAddr;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0] WriteData;
    logic [N_WRITE-1:0][NBYTES-1:0]     WriteBE;

    modport master (
        output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE,
        input  ReadData
    );

    modport slave (
        input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE,
        output ReadData
    );
endinterface

// File: rtl/register_file_multi_port.sv
// Flip-flop register file with N_READ read ports and N_WRITE byte-enabled write ports.
// Writes pass through one pending stage; reads bypass from that stage (write-first).
module register_file_multi_port #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_READ     = 2,
    parameter int unsigned N_WRITE    = 2
) (
    input  logic clk,
    input  logic rst,
    register_file_multi_port_if.slave io_bus
);
    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned NBYTES    = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]              r_mem [NUM_WORDS];
    logic [N_WRITE-1:0]                 r_wr_vld;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0] r_wr_addr;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0] r_wr_data;
    logic [N_WRITE-1:0][NBYTES-1:0]     r_wr_be;
    logic [N_READ-1:0][ADDR_WIDTH-1:0]  r_rd_addr;

    // Overlay pending writes onto a word; the lowest-index port claims each byte first.
    function automatic logic [DATA_WIDTH-1:0] merge_pending(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] base
    );
        logic [DATA_WIDTH-1:0] result;
        logic [NBYTES-1:0]     taken;
        result = base;
        taken  = '0;
        for (int unsigned w = 0; w < N_WRITE; w++) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (r_wr_vld[w] && (r_wr_addr[w] == addr) && r_wr_be[w][b] && !taken[b]) begin
                    result[8*b +: 8] = r_wr_data[w][8*b +: 8];
                    taken[b]         = 1'b1;
                end
            end
        end
        return result;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_vld  <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_be   <= '0;
        end else begin
            r_wr_vld <= io_bus.WriteEnable;
            for (int unsigned w = 0; w < N_WRITE; w++) begin
                if (io_bus.WriteEnable[w]) begin
                    r_wr_addr[w] <= io_bus.WriteAddr[w];
                    r_wr_data[w] <= io_bus.WriteData[w];
                    r_wr_be[w]   <= io_bus.WriteBE[w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned a = 0; a < NUM_WORDS; a++) begin
            if (rst) begin
                r_mem[a] <= '0;
            end else begin
                r_mem[a] <= merge_pending(ADDR_WIDTH'(a), r_mem[a]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
        end else begin
            for (int unsigned r = 0; r < N_READ; r++) begin
                if (io_bus.ReadEnable[r]) begin
                    r_rd_addr[r] <= io_bus.ReadAddr[r];
                end
            end
        end
    end

    // Held addresses keep following commits and bypasses; nothing is frozen here.
    always_comb begin
        io_bus.ReadData = '0;
        for (int unsigned r = 0; r < N_READ; r++) begin
            io_bus.ReadData[r] = merge_pending(r_rd_addr[r], r_mem[r_rd_addr[r]]);
        end
    end
endmodule
